// File: rtl/mux8_to_1_16bit.sv
//------------------------------------------------------------------------------
// mux8_to_1_16bit : registered 8-to-1 word multiplexer with capture enable
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux8_to_1_16bit #(
  parameter int                 WIDTH   = 16,
  parameter int                 SEL_W   = 3,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WIDTH-1:0]  in0,
  input  logic [WIDTH-1:0]  in1,
  input  logic [WIDTH-1:0]  in2,
  input  logic [WIDTH-1:0]  in3,
  input  logic [WIDTH-1:0]  in4,
  input  logic [WIDTH-1:0]  in5,
  input  logic [WIDTH-1:0]  in6,
  input  logic [WIDTH-1:0]  in7,
  input  logic [SEL_W-1:0]  S,
  output logic [WIDTH-1:0]  O,
  output logic [SEL_W-1:0]  S_q
);

  localparam int c_NUM_IN = 2 ** SEL_W;

  logic [WIDTH-1:0] w_words [c_NUM_IN];
  logic [WIDTH-1:0] o_d;
  logic [WIDTH-1:0] o_q;
  logic [SEL_W-1:0] sel_d;
  logic [SEL_W-1:0] sel_q;

  // Gather the inputs into an array so the select decodes as a plain index.
  assign w_words[0] = in0;
  assign w_words[1] = in1;
  assign w_words[2] = in2;
  assign w_words[3] = in3;
  assign w_words[4] = in4;
  assign w_words[5] = in5;
  assign w_words[6] = in6;
  assign w_words[7] = in7;

  always_comb begin
    o_d   = o_q;
    sel_d = sel_q;
    if (en) begin
      o_d   = w_words[S];
      sel_d = S;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_q   <= RST_VAL;
      sel_q <= '0;
    end else begin
      o_q   <= o_d;
      sel_q <= sel_d;
    end
  end

  assign O   = o_q;
  assign S_q = sel_q;

endmodule

`default_nettype wire

// File: tb/tb_mux8_to_1_16bit.sv
//------------------------------------------------------------------------------
// tb_mux8_to_1_16bit : directed plus randomized bench with a behavioural model
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux8_to_1_16bit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [2:0]  S   = '0;
  logic [15:0] data [8];
  logic [15:0] O;
  logic [2:0]  S_q;

  logic [15:0] m_o;
  logic [2:0]  m_s;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  mux8_to_1_16bit #(.WIDTH(16), .SEL_W(3), .RST_VAL(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .in0 (data[0]),
    .in1 (data[1]),
    .in2 (data[2]),
    .in3 (data[3]),
    .in4 (data[4]),
    .in5 (data[5]),
    .in6 (data[6]),
    .in7 (data[7]),
    .S   (S),
    .O   (O),
    .S_q (S_q)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge: the model applies the rules to the values present at the edge.
  task automatic step(input string tag);
    @(posedge clk);
    if (rst) begin
      m_o = 16'h0000;
      m_s = 3'd0;
    end else if (en) begin
      m_o = data[S];
      m_s = S;
    end
    #1;
    check({tag, ".O"}, {16'h0, O}, {16'h0, m_o});
    check({tag, ".S_q"}, {29'h0, S_q}, {29'h0, m_s});
  endtask

  task automatic load_ramp();
    for (int k = 0; k < 8; k++) data[k] = 16'(11 * k);
  endtask

  initial begin
    m_o = 'x;
    m_s = 'x;
    load_ramp();

    // Reset with arbitrary inputs present
    rst = 1'b1; en = 1'b1; S = 3'd5;
    repeat (2) begin
      step("reset");
      check("reset_const", {16'h0, O}, 32'd0);
    end

    // Select sweep
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      S = 3'(k);
      step("sweep");
      check("sweep_const", {16'h0, O}, 32'(11 * k));
    end

    // Enable hold
    S = 3'd4;
    step("hold_load");
    en = 1'b0; S = 3'd7; data[4] = 16'hFFFF;
    repeat (3) begin
      step("hold");
      check("hold_const", {16'h0, O}, 32'd44);
    end
    en = 1'b1;
    step("hold_release");
    check("release_const", {16'h0, O}, 32'd77);

    // Full-width, bit-exact
    for (int k = 0; k < 8; k++) data[k] = 16'h0000;
    data[3] = 16'hA5C3; data[6] = 16'h8001;
    S = 3'd3; step("bits");
    check("bits_a5c3", {16'h0, O}, 32'h0000A5C3);
    S = 3'd6; step("bits");
    check("bits_8001", {16'h0, O}, 32'h00008001);

    // Mid-operation reset
    load_ramp();
    S = 3'd5; step("mid");
    check("mid_55", {16'h0, O}, 32'd55);
    rst = 1'b1; step("mid_rst");
    check("mid_rst_0", {16'h0, O}, 32'd0);
    rst = 1'b0; S = 3'd2; step("mid_after");
    check("mid_22", {16'h0, O}, 32'd22);

    // Same-edge change of select and data
    S = 3'd1; data[1] = 16'd999; step("same_edge");
    check("same_edge_999", {16'h0, O}, 32'd999);

    // Randomized traffic; inputs also wiggle between edges
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 8; k++) data[k] = 16'($urandom);
      S   = 3'($urandom_range(7, 0));
      en  = ($urandom_range(3, 0) != 0);
      rst = ($urandom_range(19, 0) == 0);
      step("rand");
      for (int k = 0; k < 8; k++) data[k] = 16'($urandom);
      S = 3'($urandom_range(7, 0));
      en = 1'b1;
      #2;
      check("between_edges", {16'h0, O}, {16'h0, m_o});
      S = 3'($urandom_range(7, 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
